branch_predictor: RTL
=====================

# branch_predictor

Dynamic conditional-branch predictor for the fetch stage. It uses a table of 2-bit saturating counters indexed by PC and answers fetch-time taken/not-taken queries one cycle after request. It also consumes the resolved outcome that the execute-stage jump controller produces, the PC-select flag PCS together with the branch-enable flag BE, to train the table and raise a registered mispredict/flush pulse. It sits between the PC generator (query side) and the execute-stage jump control (resolution side).

## Interface
Parameters:
- `XLEN`, default 32: PC width.
- `IDX_W`, default 6: table index width; table has 2^IDX_W entries.
- `GHR_W`, default `IDX_W`: global history width; must be ≤ `IDX_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pred_valid`  in  1  fetch query strobe.
- `pred_pc`  in  XLEN  PC being fetched.
- `pred_rsp_valid`  out  1  response valid, exactly one cycle after `pred_valid`.
- `pred_taken`  out  1  predicted taken.
- `pred_ghr`  out  GHR_W  history snapshot used for the prediction; fetch carries it down the pipe.
- `upd_valid`  in  1  resolution strobe from execute.
- `upd_pc`  in  XLEN  PC of the resolved instruction.
- `upd_be`  in  1  instruction is a conditional branch (BE).
- `upd_pcs`  in  1  resolved taken (PCS).
- `upd_pred`  in  1  `pred_taken` originally returned for this instruction.
- `upd_ghr`  in  GHR_W  `pred_ghr` originally returned for this instruction.
- `mispredict`  out  1  registered one-cycle flush pulse.
- `mispred_cnt`  out  16  saturating mispredict counter.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is bit[1].
- Index without the macro: `pc[IDX_W+1:2]`. Index with the macro: see Configuration.
- Training happens only when `upd_valid && upd_be`:
  - `upd_pcs=1`: counter increments, saturating at 11.
  - `upd_pcs=0`: counter decrements, saturating at 00.
- Mispredict condition when `upd_valid` is high:
  - `upd_be=1` and `upd_pcs != upd_pred`, or
  - `upd_be=0` and `upd_pred=1` (a non-branch was predicted taken).
- When the mispredict condition holds, `mispredict` pulses high the following cycle and `mispred_cnt` increments, saturating at 16'hFFFF.
- `upd_valid=0`: no table, GHR, counter or mispredict effect.
- Simultaneous query and update to the same index: the query returns the pre-update counter value (read-before-write). The update still commits.
- Back-to-back updates to the same index each apply in order, e.g. 01 → 10 → 11 over two taken updates.

## Timing
- Query: `pred_valid` sampled at edge N, so `pred_rsp_valid`, `pred_taken` and `pred_ghr` are valid during cycle N+1. With `pred_valid=0`, `pred_rsp_valid=0` and `pred_taken=0` next cycle.
- Update: table and GHR write at edge N. `mispredict` is high during cycle N+1 only. `mispred_cnt` reflects the increment from cycle N+1.
- Throughput: one query and one update per cycle, independently.
- Reset (async assert, any time, including mid-query or mid-update):
  - All counters are cleared to 01.
  - GHR is cleared to 0.
  - `pred_rsp_valid`, `pred_taken`, `pred_ghr`, `mispredict` and `mispred_cnt` are cleared to 0.
  - An in-flight response or update is discarded.
- Deassertion: the first edge with `rst_n=1` is a normal operating edge.

## Configuration
- Macro `BRANCH_PREDICTOR_GSHARE_EN`.
- Defined:
  - Query index is `pc[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}`.
  - Update index uses `upd_ghr` in place of `ghr`.
  - GHR shifts left, inserting `upd_pcs` at bit 0, on each `upd_valid && upd_be`. GHR is non-speculative.
  - `pred_ghr` outputs the current GHR.
- Undefined:
  - No GHR register exists.
  - `pred_ghr` is tied to 0 and `upd_ghr` is ignored.
  - Index is the PC bits only (bimodal).
- Ports are identical in both builds.

## Structure
- Shared package holds:
  - the counter encoding constants `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`;
  - the reset value `CNT_RST = CNT_WNT`.
- One natural sub-module, `sat_counter2`: combinational 2-bit saturating next-state from (current, taken). The top instantiates one on the update path.
- The table is a flop array, not SRAM, because of the asynchronous reset requirement.

## Test plan
- Reset, then query PC 0x100 → next cycle `pred_rsp_valid=1`, `pred_taken=0`, `mispred_cnt=0`.
- Two updates, PC 0x100, `upd_be=1`, `upd_pcs=1`, `upd_pred=0` → `mispredict` pulses twice. A subsequent query of 0x100 returns `pred_taken=1`. Four further taken updates leave the counter at 11, and a single not-taken update still predicts taken.
- Update with `upd_be=0`, `upd_pred=1` → `mispredict=1`, table unchanged (query still 01 → NT). With `upd_be=0`, `upd_pred=0` → no pulse.
- Same cycle: query and taken update on PC 0x200 from reset state → response `pred_taken=0`. Re-query next cycle → `pred_taken=1`.
- Force 0x10000 mispredicts → `mispred_cnt` holds 16'hFFFF. Assert `rst_n=0` mid-stream → all outputs 0 immediately, and every entry predicts NT afterwards.
- With `BRANCH_PREDICTOR_GSHARE_EN`:
  - Train PC 0x40 taken with `upd_ghr=6'b000001` → GHR becomes 6'b000001.
  - A query of 0x40 now returns `pred_ghr=1` and uses index 0x10^0x01. That entry is 10 → taken.
  - A query of PC 0x44 uses index 0x11^0x01 = 0x10, which is untrained → NT.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared 2-bit saturating counter encodings for the branch predictor.
package branch_predictor_pkg;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;
   localparam logic [1:0] CNT_RST = CNT_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational 2-bit saturating counter next-state: count up on taken, down otherwise.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (taken_i) begin
         if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter predictor; response one cycle after query, no backpressure.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a non-speculative global history into the index.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6,
   parameter int GHR_W = IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pred_valid,
   input  logic [XLEN-1:0]   pred_pc,
   output logic              pred_rsp_valid,
   output logic              pred_taken,
   output logic [GHR_W-1:0]  pred_ghr,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_be,
   input  logic              upd_pcs,
   input  logic              upd_pred,
   input  logic [GHR_W-1:0]  upd_ghr,
   output logic              mispredict,
   output logic [15:0]       mispred_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]       tbl_q [ENTRIES];
   logic [IDX_W-1:0] q_idx;
   logic [IDX_W-1:0] u_idx;
   logic [1:0]       upd_cnt_nxt;
   logic             train;
   logic             mis_d;
   logic             rsp_vld_q;
   logic             taken_d, taken_q;
   logic             mis_q;
   logic [15:0]      cnt_d, cnt_q;
   logic             unused_pc;

   assign train = upd_valid & upd_be;

   // A non-branch predicted taken redirected fetch wrongly, so it flushes too.
   assign mis_d = upd_valid & (upd_be ? (upd_pcs != upd_pred) : upd_pred);
   assign cnt_d = (mis_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

   assign unused_pc = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                        upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [GHR_W-1:0] ghr_d, ghr_q, rsp_ghr_q;

   assign q_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign u_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
   assign ghr_d = train ? ((ghr_q << 1) | GHR_W'(upd_pcs)) : ghr_q;
   assign pred_ghr = rsp_ghr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_q     <= '0;
         rsp_ghr_q <= '0;
      end else begin
         ghr_q     <= ghr_d;
         rsp_ghr_q <= pred_valid ? ghr_q : '0;
      end
   end
`else
   logic unused_ghr;

   assign q_idx      = pred_pc[IDX_W+1:2];
   assign u_idx      = upd_pc[IDX_W+1:2];
   assign pred_ghr   = '0;
   assign unused_ghr = ^upd_ghr;
`endif

   sat_counter2 u_sat (
      .cnt_i   (tbl_q[u_idx]),
      .taken_i (upd_pcs),
      .cnt_o   (upd_cnt_nxt)
   );

   // Query reads the pre-edge table, so a same-cycle update is not visible yet.
   assign taken_d = pred_valid & tbl_q[q_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CNT_RST;
      end else if (train) begin
         tbl_q[u_idx] <= upd_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q <= 1'b0;
         taken_q   <= 1'b0;
         mis_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         rsp_vld_q <= pred_valid;
         taken_q   <= taken_d;
         mis_q     <= mis_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pred_rsp_valid = rsp_vld_q;
   assign pred_taken     = taken_q;
   assign mispredict     = mis_q;
   assign mispred_cnt    = cnt_q;

endmodule
